// File: rtl/mips_cpu_mem_pkg.sv
// Shared constants and address-region decode for the MIPS CPU Avalon memory model.
package mips_cpu_mem_pkg;

  localparam logic [31:0] INSTR_BASE = 32'hBFC0_0000;
  localparam logic [31:0] DATA_BASE  = 32'h0000_0000;

  typedef enum logic [1:0] {
    REG_INSTR,
    REG_DATA,
    REG_NONE
  } region_e;

  // Offsets wrap below each base, so one unsigned compare covers both range ends.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] bank_bytes);
    logic [31:0] instr_off;
    logic [31:0] data_off;
    instr_off = addr - INSTR_BASE;
    data_off  = addr - DATA_BASE;
    if (instr_off < bank_bytes)
      return REG_INSTR;
    else if (data_off < bank_bytes)
      return REG_DATA;
    else
      return REG_NONE;
  endfunction

endpackage

// File: rtl/mips_cpu_ram_bank.sv
// Single-port word-wide RAM with byte-lane write enables and registered read;
// contents start at zero.
module mips_cpu_ram_bank #(
  parameter int    WORDS     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  initial begin
    for (int i = 0; i < WORDS; i++)
      mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_cpu_avalon_ram.sv
// Avalon-MM slave memory: instruction bank at the reset vector, data bank at 0,
// programmable waitrequest stall and one-cycle read latency.
module mips_cpu_avalon_ram
  import mips_cpu_mem_pkg::*;
#(
  parameter string RAM_INIT_FILE = "",
  parameter int    WAIT_CYCLES   = 1,
  parameter int    BANK_WORDS    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata
);

  localparam int AW = $clog2(BANK_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX   = CW'(WAIT_CYCLES);
  localparam logic [31:0]   BANK_BYTES = 32'(4 * BANK_WORDS);

  logic [CW-1:0] cnt_reg;
  region_e       sel_reg;
  region_e       region;
  logic          req;
  logic          accept;
  logic [AW-1:0] word;
  logic [31:0]   instr_rdata;
  logic [31:0]   data_rdata;
  logic          instr_re, instr_we, data_re, data_we;

  assign req         = read | write;
  assign waitrequest = req & (cnt_reg < WAIT_MAX);
  assign accept      = req & ~waitrequest & ~reset;
  assign region      = decode_region(address, BANK_BYTES);
  assign word        = address[AW+1:2];

  // A simultaneous read+write is treated as a write only.
  assign instr_we = accept & write & (region == REG_INSTR);
  assign data_we  = accept & write & (region == REG_DATA);
  assign instr_re = accept & read & ~write & (region == REG_INSTR);
  assign data_re  = accept & read & ~write & (region == REG_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      sel_reg <= REG_NONE;
    end else begin
      if (!req || accept)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;
      if (accept && read && !write)
        sel_reg <= region;
    end
  end

  // Bank output registers only load on their own accepted reads, so the mux
  // selection alone is enough to hold readdata between reads.
  always_comb begin
    readdata = '0;
    case (sel_reg)
      REG_INSTR: readdata = instr_rdata;
      REG_DATA:  readdata = data_rdata;
      default:   readdata = '0;
    endcase
  end

  mips_cpu_ram_bank #(.WORDS(BANK_WORDS), .INIT_FILE(RAM_INIT_FILE)) u_instr_bank (
    .clk   (clk),
    .re    (instr_re),
    .we    (instr_we),
    .be    (byteenable),
    .addr  (word),
    .wdata (writedata),
    .rdata (instr_rdata)
  );

  mips_cpu_ram_bank #(.WORDS(BANK_WORDS), .INIT_FILE("")) u_data_bank (
    .clk   (clk),
    .re    (data_re),
    .we    (data_we),
    .be    (byteenable),
    .addr  (word),
    .wdata (writedata),
    .rdata (data_rdata)
  );

endmodule

// File: tb/tb_mips_cpu_avalon_ram.sv
// Directed bench for mips_cpu_avalon_ram: a 2-cycle-stall instance for most
// checks and a zero-stall instance sharing address/data for the no-wait case.
module tb_mips_cpu_avalon_ram;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic        read, write, nw_read, nw_write;
  logic        waitrequest, nw_waitrequest;
  logic [31:0] readdata, nw_readdata;
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu_avalon_ram #(.RAM_INIT_FILE(""), .WAIT_CYCLES(WAIT), .BANK_WORDS(4096)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  mips_cpu_avalon_ram #(.RAM_INIT_FILE(""), .WAIT_CYCLES(0), .BANK_WORDS(4096)) dut_nw (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .byteenable  (byteenable),
    .read        (nw_read),
    .write       (nw_write),
    .writedata   (writedata),
    .waitrequest (nw_waitrequest),
    .readdata    (nw_readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the stalling instance; checks the stall length and
  // returns readdata sampled the cycle after the accepting edge.
  task automatic xfer(input logic do_rd, input logic do_wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d, input string tag,
                      output logic [31:0] data_out);
    int stalls = 0;
    @(negedge clk);
    address = a; byteenable = be; writedata = d; read = do_rd; write = do_wr;
    #1;
    while (waitrequest === 1'b1 && stalls < 10) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check({tag, " stalls"}, 32'(stalls), 32'(WAIT));
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    data_out = readdata;
    $display("xfer %s addr=%h be=%b rd=%b wr=%b wdata=%h readdata=%h stalls=%0d",
             tag, a, be, do_rd, do_wr, d, data_out, stalls);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; nw_read = 1'b0; nw_write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset readdata", readdata, 32'h0);
    check("reset nw readdata", nw_readdata, 32'h0);
    check("idle waitrequest", 32'(waitrequest), 32'h0);

    xfer(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, "instr blank", rd);
    check("instr blank", rd, 32'h0);
    xfer(1'b0, 1'b1, 32'hBFC0_0000, 4'hF, 32'h2402_0005, "instr wr", rd);
    xfer(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, "instr rd", rd);
    check("instr rd", rd, 32'h2402_0005);

    // Zero-stall instance: waitrequest never rises, data one cycle later.
    @(negedge clk);
    address = 32'hBFC0_0000; writedata = 32'h2402_0005; byteenable = 4'hF; nw_write = 1'b1;
    #1;
    check("nw write waitrequest", 32'(nw_waitrequest), 32'h0);
    @(negedge clk);
    nw_write = 1'b0; nw_read = 1'b1;
    #1;
    check("nw read waitrequest", 32'(nw_waitrequest), 32'h0);
    @(negedge clk);
    nw_read = 1'b0;
    check("nw readdata", nw_readdata, 32'h2402_0005);
    $display("xfer nw read addr=bfc00000 readdata=%h", nw_readdata);

    xfer(1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, "full wr", rd);
    xfer(1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, "full rd", rd);
    check("full rd", rd, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA, "lane0 wr", rd);
    xfer(1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, "lane0 rd", rd);
    check("lane0 rd", rd, 32'hDEAD_BEAA);
    xfer(1'b0, 1'b1, 32'h0000_0010, 4'b1100, 32'h1234_0000, "upper wr", rd);
    xfer(1'b1, 1'b0, 32'h0000_0010, 4'b0001, 32'h0, "upper rd be ignored", rd);
    check("upper rd be ignored", rd, 32'h1234_BEAA);

    xfer(1'b0, 1'b1, 32'hBFC0_3FFC, 4'hF, 32'hCAFE_F00D, "instr last wr", rd);
    xfer(1'b1, 1'b0, 32'hBFC0_3FFC, 4'hF, 32'h0, "instr last rd", rd);
    check("instr last rd", rd, 32'hCAFE_F00D);

    xfer(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0, "unmapped rd", rd);
    check("unmapped rd", rd, 32'h0);
    xfer(1'b0, 1'b1, 32'h8000_0000, 4'hF, 32'h1234_5678, "unmapped wr", rd);
    xfer(1'b0, 1'b1, 32'h0000_4000, 4'hF, 32'h8765_4321, "past data wr", rd);
    xfer(1'b0, 1'b1, 32'hBFC0_4000, 4'hF, 32'h0BAD_F00D, "past instr wr", rd);
    xfer(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, "data word0", rd);
    check("data word0", rd, 32'h0);
    xfer(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, "data word4", rd);
    check("data word4", rd, 32'h1234_BEAA);
    xfer(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, "instr word0", rd);
    check("instr word0", rd, 32'h2402_0005);

    xfer(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h5555_5555, "rd+wr", rd);
    check("rd+wr holds readdata", rd, 32'h2402_0005);
    xfer(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, "rd+wr written", rd);
    check("rd+wr written", rd, 32'h5555_5555);

    // Reset in the middle of a stalled write aborts it.
    @(negedge clk);
    address = 32'h0000_0020; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; write = 1'b1;
    #1;
    check("stalled write waitrequest", 32'(waitrequest), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; write = 1'b0;
    #1;
    check("abort readdata", readdata, 32'h0);
    check("abort waitrequest", 32'(waitrequest), 32'h0);
    $display("xfer reset-abort addr=00000020 readdata=%h", readdata);
    xfer(1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, "abort word", rd);
    check("abort word", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
